// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the program loader.
package loader_pkg;

   localparam logic [7:0] MAGIC = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN0 = 3'd1,
      ST_LEN1 = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_e;

endpackage

// File: rtl/ld_timeout.sv
// Inter-byte idle counter; flags once TIMEOUT enabled cycles pass without a clear.
module ld_timeout #(
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [31:0] cnt_q, cnt_d;
   logic        expired_q, expired_d;

   always_comb begin
      cnt_d     = '0;
      expired_d = 1'b0;
      if (enable && !clear) begin
         cnt_d     = cnt_q + 32'd1;
         expired_d = (cnt_d >= 32'(TIMEOUT));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   assign expired = expired_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses magic/length/words/checksum frames into
// instruction-memory writes and holds the core in reset until a good load.
module prog_loader
   import loader_pkg::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        write,
   output logic [31:0] addr_in,
   output logic [31:0] data,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] idx_q, idx_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [31:0] word_q, word_d;
   logic [7:0]  csum_q, csum_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        hold_q, hold_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic [15:0] len_full;
   logic        in_frame;
   logic        expired;

   assign in_frame = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);

   ld_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (rx_valid),
      .enable  (in_frame),
      .expired (expired)
   );

   // Next-state and registered-output logic; timeout takes priority over a byte.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      idx_d    = idx_q;
      bcnt_d   = bcnt_q;
      word_d   = word_q;
      csum_d   = csum_q;
      write_d  = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      hold_d   = hold_q;
      done_d   = done_q;
      error_d  = error_q;
      len_full = {rx_byte, len_q[7:0]};

      if (expired && in_frame) begin
         state_d = ST_ERR;
         error_d = 1'b1;
         hold_d  = 1'b1;
      end else if (rx_valid) begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (rx_byte == MAGIC) begin
                  state_d = ST_LEN0;
                  done_d  = 1'b0;
                  error_d = 1'b0;
                  hold_d  = 1'b1;
                  idx_d   = '0;
                  bcnt_d  = '0;
                  csum_d  = '0;
               end
            end
            ST_LEN0: begin
               len_d   = {8'h00, rx_byte};
               state_d = ST_LEN1;
            end
            ST_LEN1: begin
               len_d = len_full;
               if (len_full == 16'd0) begin
                  state_d = ST_CSUM;
               end else if (len_full > 16'(DEPTH)) begin
                  state_d = ST_ERR;
                  error_d = 1'b1;
                  hold_d  = 1'b1;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               word_d[8*bcnt_q +: 8] = rx_byte;
               csum_d = csum_q ^ rx_byte;
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  write_d = 1'b1;
                  addr_d  = 32'(idx_q);
                  data_d  = {rx_byte, word_q[23:0]};
                  idx_d   = idx_q + 16'd1;
                  if (idx_q == len_q - 16'd1) begin
                     state_d = ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               if (rx_byte == csum_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ST_ERR;
                  error_d = 1'b1;
                  hold_d  = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         csum_q  <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
         csum_q  <= csum_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign write    = write_q;
   assign addr_in  = addr_q;
   assign data     = data_q;
   assign cpu_hold = hold_q;
   assign done     = done_q;
   assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames with hand-computed writes and status.
module tb_prog_loader;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned TIMEOUT = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        write;
   logic [31:0] addr_in;
   logic [31:0] data;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          wr_cnt   = 0;
   logic [31:0] wr_addr [16];
   logic [31:0] wr_data [16];

   prog_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .write    (write),
      .addr_in  (addr_in),
      .data     (data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   // Record every cycle the write strobe is high, sampled mid-cycle.
   always @(negedge clk) begin
      if (write === 1'b1) begin
         if (wr_cnt < 16) begin
            wr_addr[wr_cnt] = addr_in;
            wr_data[wr_cnt] = data;
         end
         wr_cnt = wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_good_body(input logic [7:0] csum);
      send(8'h02); send(8'h00);
      send(8'h13); send(8'h00); send(8'h10); send(8'h00);
      send(8'h6F); send(8'hF0); send(8'hDF); send(8'hFF);
      send(csum);
   endtask

   task automatic check_good_writes(input string tag);
      check({tag, "_wrcnt"}, 32'(wr_cnt), 32'd2);
      check({tag, "_a0"}, wr_addr[0], 32'd0);
      check({tag, "_d0"}, wr_data[0], 32'h0010_0013);
      check({tag, "_a1"}, wr_addr[1], 32'd1);
      check({tag, "_d1"}, wr_data[1], 32'hFFDF_F06F);
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      idle(3);
      check("rst_write", 32'(write), 32'd0);
      check("rst_addr", addr_in, 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Good frame, XOR of word bytes = 0xBC.
      wr_cnt = 0;
      send(8'h13);
      check("idle_ignore_done", 32'(done), 32'd0);
      send(8'hA5);
      send_good_body(8'hBC);
      idle(2);
      check_good_writes("good");
      check("good_done", 32'(done), 32'd1);
      check("good_hold", 32'(cpu_hold), 32'd0);
      check("good_error", 32'(error), 32'd0);
      check("hold_addr", addr_in, 32'd1);
      check("hold_data", data, 32'hFFDF_F06F);
      send(8'h13);
      check("done_ignore", 32'(done), 32'd1);

      // Bad checksum: writes still land, then error.
      wr_cnt = 0;
      send(8'hA5);
      check("restart_done", 32'(done), 32'd0);
      check("restart_hold", 32'(cpu_hold), 32'd1);
      send_good_body(8'hBD);
      idle(2);
      check_good_writes("bad");
      check("bad_error", 32'(error), 32'd1);
      check("bad_hold", 32'(cpu_hold), 32'd1);
      check("bad_done", 32'(done), 32'd0);

      // Count 17 exceeds depth: error right after second length byte.
      wr_cnt = 0;
      send(8'hA5);
      check("ovf_err_clr", 32'(error), 32'd0);
      send(8'h11);
      send(8'h00);
      check("ovf_error", 32'(error), 32'd1);
      idle(4);
      check("ovf_wrcnt", 32'(wr_cnt), 32'd0);

      // Stall after two data bytes.
      wr_cnt = 0;
      send(8'hA5); send(8'h02); send(8'h00); send(8'h13); send(8'h00);
      idle(TIMEOUT / 2);
      check("to_early", 32'(error), 32'd0);
      idle(TIMEOUT);
      check("to_error", 32'(error), 32'd1);
      check("to_hold", 32'(cpu_hold), 32'd1);
      check("to_wrcnt", 32'(wr_cnt), 32'd0);
      send(8'hA5);
      send_good_body(8'hBC);
      idle(2);
      check_good_writes("to_good");
      check("to_good_done", 32'(done), 32'd1);

      // Empty frame.
      wr_cnt = 0;
      send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
      idle(2);
      check("empty_done", 32'(done), 32'd1);
      check("empty_hold", 32'(cpu_hold), 32'd0);
      check("empty_wrcnt", 32'(wr_cnt), 32'd0);
      send(8'hA5);
      check("empty_re_hold", 32'(cpu_hold), 32'd1);
      check("empty_re_done", 32'(done), 32'd0);
      idle(TIMEOUT + 4);

      // Magic bytes inside a frame are plain data; XOR of four A5 = 0.
      wr_cnt = 0;
      send(8'hA5); send(8'h01); send(8'h00);
      send(8'hA5); send(8'hA5); send(8'hA5); send(8'hA5);
      send(8'h00);
      idle(2);
      check("mid_wrcnt", 32'(wr_cnt), 32'd1);
      check("mid_a0", wr_addr[0], 32'd0);
      check("mid_d0", wr_data[0], 32'hA5A5_A5A5);
      check("mid_done", 32'(done), 32'd1);

      // Reset in the middle of a 16-word frame.
      send(8'hA5); send(8'h10); send(8'h00);
      check("max_len_ok", 32'(error), 32'd0);
      send(8'h11); send(8'h22);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst_write", 32'(write), 32'd0);
      check("mrst_addr", addr_in, 32'd0);
      check("mrst_data", data, 32'd0);
      check("mrst_hold", 32'(cpu_hold), 32'd1);
      check("mrst_done", 32'(done), 32'd0);
      check("mrst_error", 32'(error), 32'd0);
      wr_cnt = 0;
      idle(2);
      rst_n = 1'b1;
      send(8'hA5);
      send_good_body(8'hBC);
      idle(2);
      check_good_writes("post_rst");
      check("post_rst_done", 32'(done), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 16, is the instruction memory size in 32-bit words.
REQ-002 Parameter TIMEOUT, default 100000, is the maximum number of clk cycles allowed between accepted bytes mid-frame.
REQ-003 Port clk, input, 1: single clock, all state on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port rx_valid, input, 1: a byte is present on rx_byte this cycle, one-cycle pulse from the upstream receiver.
REQ-006 Port rx_byte, input, 8: received byte.
REQ-007 Port write, output, 1: instruction-memory write strobe.
REQ-008 Port addr_in, output, 32: memory word index, not a byte address.
REQ-009 Port data, output, 32: word to write.
REQ-010 Port cpu_hold, output, 1: holds the core in reset while high.
REQ-011 Port done, output, 1: the last load completed with a good checksum.
REQ-012 Port error, output, 1: the last load aborted.

Function
REQ-013 The frame format SHALL be: magic 0xA5; count N as 16-bit little-endian; N words of 4 bytes each, little-endian; one checksum byte equal to the XOR of all word bytes.
REQ-014 The FSM SHALL have the states IDLE, LEN0, LEN1, DATA, CSUM, DONE and ERR, and SHALL advance only on rx_valid, apart from the timeout.
REQ-015 In IDLE, DONE or ERR, byte 0xA5 SHALL move the FSM to LEN0, clear done and error, set cpu_hold, and zero the word index and checksum; any other byte SHALL be ignored.
REQ-016 The FSM SHALL step LEN0 to LEN1 to DATA; when N == 0 it SHALL go from LEN1 directly to CSUM.
REQ-017 When N > DEPTH, the FSM SHALL go from LEN1 to ERR with no writes performed.
REQ-018 In DATA, each byte SHALL shift into byte lane k = byte_cnt[1:0] and be XORed into the checksum.
REQ-019 On the 4th byte of a word, write SHALL pulse high for exactly one cycle in the following cycle, with addr_in equal to the word index and data equal to the assembled word; the index then increments.
REQ-020 After word N-1, the FSM SHALL move to CSUM.
REQ-021 In CSUM, a matching byte SHALL go to DONE (done=1, cpu_hold=0); a mismatching byte SHALL go to ERR (error=1, cpu_hold=1).
REQ-022 Words already written before an error SHALL NOT be rolled back.
REQ-023 In LEN0, LEN1, DATA and CSUM, a 32-bit idle counter SHALL reset on each rx_valid; reaching TIMEOUT SHALL move the FSM to ERR.
REQ-024 addr_in and data SHALL hold their last values when write is low.
REQ-025 The upper bits of addr_in SHALL be zero.
REQ-026 A 0xA5 byte received mid-frame SHALL be treated as data or length, never as a restart.

Reset
REQ-027 While rst_n is low, the state SHALL be IDLE and write=0, addr_in=0, data=0, cpu_hold=1, done=0, error=0, with all counters and the checksum zero.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; the next frame SHALL start at word index 0.
REQ-029 No write pulse SHALL be emitted during reset or in the cycle reset is released.

Structure
REQ-030 The magic value 0xA5 and the state encoding SHALL live in the shared package loader_pkg.
REQ-031 The idle/timeout counter SHALL be one sub-module, named ld_timeout, with inputs clear and enable and output expired.
REQ-032 The block SHALL connect directly to the instruction-memory write, addr_in and data ports, and its cpu_hold SHALL gate the core reset.

Verification
REQ-033 Frame A5 02 00 13 00 10 00 6F F0 DF FF xx (correct XOR) -> writes {0:0x00100013, 1:0xFFDFF06F}, then done=1 and cpu_hold=0.
REQ-034 Same frame with checksum byte XOR 0x01 -> both writes occur, then error=1 and cpu_hold=1.
REQ-035 Count 0x0011 with DEPTH=16 -> no write, error=1 right after the second length byte.
REQ-036 Stall of TIMEOUT cycles after 2 data bytes -> error=1; a following full good frame -> done=1.
REQ-037 Frame A5 00 00 00 -> done=1 with zero writes; a further A5 -> cpu_hold=1 and done=0.
REQ-038 rst_n pulsed low mid-DATA -> all outputs at their reset values; a following good frame writes starting at addr_in=0.
